// File: rtl/byte_unstriping.sv
// Re-serialises 4-lane striped words into one byte stream, lane 0 first, with a one-word pending buffer.
// Optional BYTE_UNSTRIPING_COUNT_EN adds a 16-bit byteCount of emitted bytes.
module byte_unstriping #(
   parameter int DATA_W = 8
) (
   input  logic              clk1Mhz,
   input  logic              reset,
   input  logic              laneStrobe,
   input  logic [DATA_W-1:0] stripedLane0,
   input  logic [DATA_W-1:0] stripedLane1,
   input  logic [DATA_W-1:0] stripedLane2,
   input  logic [DATA_W-1:0] stripedLane3,
   input  logic              lane0VLD,
   input  logic              lane1VLD,
   input  logic              lane2VLD,
   input  logic              lane3VLD,
   output logic [DATA_W-1:0] byteUnstripingOUT,
   output logic              byteUnstripingVLD,
   output logic [1:0]        contador,
   output logic              alignErr,
   output logic              overrun
`ifdef BYTE_UNSTRIPING_COUNT_EN
   ,
   output logic [15:0]       byteCount
`endif
);

   localparam int WORD_W = 4 * DATA_W;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [WORD_W-1:0] act_q, act_d;
   logic [WORD_W-1:0] pend_q, pend_d;
   logic [1:0]        act_last_q, act_last_d;
   logic [1:0]        pend_last_q, pend_last_d;
   logic              pend_full_q, pend_full_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] out_q, out_d;
   logic              vld_q, vld_d;
   logic              align_q, align_d;
   logic              ovr_q, ovr_d;

   logic [3:0]        vpat;
   logic [WORD_W-1:0] word_in;
   logic              strobe_legal;
   logic              strobe_bad;
   logic [1:0]        in_last;
   logic              last_byte;

   function automatic logic [DATA_W-1:0] lane_sel(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        idx);
      return w[int'(idx)*DATA_W +: DATA_W];
   endfunction

   assign vpat    = {lane3VLD, lane2VLD, lane1VLD, lane0VLD};
   assign word_in = {stripedLane3, stripedLane2, stripedLane1, stripedLane0};

   // Only contiguous-from-lane-0 patterns are legal; in_last is the index of the final lane.
   always_comb begin
      strobe_legal = 1'b0;
      in_last      = 2'd0;
      case (vpat)
         4'b0001: begin strobe_legal = laneStrobe; in_last = 2'd0; end
         4'b0011: begin strobe_legal = laneStrobe; in_last = 2'd1; end
         4'b0111: begin strobe_legal = laneStrobe; in_last = 2'd2; end
         4'b1111: begin strobe_legal = laneStrobe; in_last = 2'd3; end
         default: ;
      endcase
      strobe_bad = laneStrobe && (vpat != 4'b0000) && !strobe_legal;
   end

   assign last_byte = (state_q == ST_SHIFT) && (cnt_q == act_last_q);

   always_comb begin
      state_d     = state_q;
      act_d       = act_q;
      act_last_d  = act_last_q;
      pend_d      = pend_q;
      pend_last_d = pend_last_q;
      pend_full_d = pend_full_q;
      cnt_d       = cnt_q;
      out_d       = out_q;
      vld_d       = 1'b0;
      align_d     = strobe_bad;
      ovr_d       = ovr_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = 2'd0;
            if (strobe_legal) begin
               act_d      = word_in;
               act_last_d = in_last;
               out_d      = stripedLane0;
               vld_d      = 1'b1;
               state_d    = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            if (!last_byte) begin
               cnt_d = cnt_q + 2'd1;
               out_d = lane_sel(act_q, cnt_q + 2'd1);
               vld_d = 1'b1;
               if (strobe_legal) begin
                  if (!pend_full_q) begin
                     pend_d      = word_in;
                     pend_last_d = in_last;
                     pend_full_d = 1'b1;
                  end else begin
                     ovr_d = 1'b1;
                  end
               end
            end else if (pend_full_q) begin
               // Pending is older, so it goes first; a word arriving now takes the slot it frees.
               act_d       = pend_q;
               act_last_d  = pend_last_q;
               out_d       = lane_sel(pend_q, 2'd0);
               cnt_d       = 2'd0;
               vld_d       = 1'b1;
               pend_full_d = 1'b0;
               if (strobe_legal) begin
                  pend_d      = word_in;
                  pend_last_d = in_last;
                  pend_full_d = 1'b1;
               end
            end else if (strobe_legal) begin
               act_d      = word_in;
               act_last_d = in_last;
               out_d      = stripedLane0;
               cnt_d      = 2'd0;
               vld_d      = 1'b1;
            end else begin
               cnt_d   = 2'd0;
               state_d = ST_IDLE;
            end
         end

         default: begin
            cnt_d   = 2'd0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk1Mhz or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         act_q       <= '0;
         act_last_q  <= 2'd0;
         pend_q      <= '0;
         pend_last_q <= 2'd0;
         pend_full_q <= 1'b0;
         cnt_q       <= 2'd0;
         out_q       <= '0;
         vld_q       <= 1'b0;
         align_q     <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         act_q       <= act_d;
         act_last_q  <= act_last_d;
         pend_q      <= pend_d;
         pend_last_q <= pend_last_d;
         pend_full_q <= pend_full_d;
         cnt_q       <= cnt_d;
         out_q       <= out_d;
         vld_q       <= vld_d;
         align_q     <= align_d;
         ovr_q       <= ovr_d;
      end
   end

   assign byteUnstripingOUT = out_q;
   assign byteUnstripingVLD = vld_q;
   assign contador          = cnt_q;
   assign alignErr          = align_q;
   assign overrun           = ovr_q;

`ifdef BYTE_UNSTRIPING_COUNT_EN
   logic [15:0] byte_cnt_q;

   // Counts alongside the registered valid so byteCount includes the byte currently shown.
   always_ff @(posedge clk1Mhz or posedge reset) begin
      if (reset) begin
         byte_cnt_q <= 16'd0;
      end else begin
         byte_cnt_q <= byte_cnt_q + 16'(vld_d);
      end
   end

   assign byteCount = byte_cnt_q;
`endif

endmodule

// File: tb/tb_byte_unstriping.sv
// Self-checking bench for byte_unstriping: directed vector table, hand-written corner sequences,
// and random strobes compared per cycle against a queue-based model of the byte stream.
module tb_byte_unstriping;

  logic        clk = 1'b0;
  logic        reset;
  logic        strobe;
  logic [3:0]  vpat;
  logic [31:0] lanes;
  logic [7:0]  out;
  logic        vld;
  logic [1:0]  contador;
  logic        align_err;
  logic        overrun;
`ifdef BYTE_UNSTRIPING_COUNT_EN
  logic [15:0] byte_count;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  byte_unstriping #(.DATA_W(8)) dut (
    .clk1Mhz(clk),
    .reset(reset),
    .laneStrobe(strobe),
    .stripedLane0(lanes[7:0]),
    .stripedLane1(lanes[15:8]),
    .stripedLane2(lanes[23:16]),
    .stripedLane3(lanes[31:24]),
    .lane0VLD(vpat[0]),
    .lane1VLD(vpat[1]),
    .lane2VLD(vpat[2]),
    .lane3VLD(vpat[3]),
    .byteUnstripingOUT(out),
    .byteUnstripingVLD(vld),
    .contador(contador),
    .alignErr(align_err),
    .overrun(overrun)
`ifdef BYTE_UNSTRIPING_COUNT_EN
    ,
    .byteCount(byte_count)
`endif
  );

  // Reference model: bytes still to send of the current word, and a one-word waiting slot.
  logic [7:0] m_cur[$];
  logic [7:0] m_pend[$];
  bit         m_busy;
  bit         m_pend_full;
  logic [7:0] m_out;
  logic       m_vld;
  logic [1:0] m_idx;
  logic       m_align;
  logic       m_ovr;
  int         m_count;

  logic       obs_vld;
  logic       obs_align;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cur = {};
    m_pend = {};
    m_busy = 0;
    m_pend_full = 0;
    m_out = 8'h00;
    m_vld = 1'b0;
    m_idx = 2'd0;
    m_align = 1'b0;
    m_ovr = 1'b0;
    m_count = 0;
  endtask

  task automatic model_step();
    bit         legal;
    int         n;
    logic [7:0] bytes[$];
    legal = 0;
    n = 0;
    for (int k = 1; k <= 4; k++) begin
      if (vpat == 4'((1 << k) - 1)) begin
        legal = 1;
        n = k;
      end
    end
    legal = legal && strobe;
    m_align = strobe && (vpat != 4'b0000) && !legal;
    bytes = {};
    for (int k = 0; k < n; k++) bytes.push_back(lanes[k*8 +: 8]);

    if (m_busy && m_cur.size() > 0) begin
      m_out = m_cur.pop_front();
      m_idx = m_idx + 2'd1;
      if (legal) begin
        if (!m_pend_full) begin
          m_pend = bytes;
          m_pend_full = 1;
        end else begin
          m_ovr = 1'b1;
        end
      end
    end else if (m_busy && m_pend_full) begin
      m_cur = m_pend;
      m_out = m_cur.pop_front();
      m_idx = 2'd0;
      m_pend_full = 0;
      if (legal) begin
        m_pend = bytes;
        m_pend_full = 1;
      end
    end else if (legal) begin
      m_cur = bytes;
      m_out = m_cur.pop_front();
      m_idx = 2'd0;
      m_busy = 1;
    end else begin
      m_busy = 0;
      m_idx = 2'd0;
    end
    m_vld = m_busy;
    if (m_vld) m_count = (m_count + 1) % 65536;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    obs_vld = vld;
    obs_align = align_err;
    chk("out", {24'h0, out}, {24'h0, m_out});
    chk("vld", {31'h0, vld}, {31'h0, m_vld});
    chk("contador", {30'h0, contador}, {30'h0, m_idx});
    chk("alignErr", {31'h0, align_err}, {31'h0, m_align});
    chk("overrun", {31'h0, overrun}, {31'h0, m_ovr});
`ifdef BYTE_UNSTRIPING_COUNT_EN
    chk("byteCount", {16'h0, byte_count}, 32'(m_count));
`endif
  endtask

  task automatic step(input logic s, input logic [3:0] v, input logic [31:0] w);
    strobe = s;
    vpat = v;
    lanes = w;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), $urandom);
  endtask

  task automatic apply_reset();
    strobe = 1'b0;
    vpat = 4'b0000;
    lanes = 32'h0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out", {24'h0, out}, 32'h0);
    chk("rst_vld", {31'h0, vld}, 32'h0);
    chk("rst_contador", {30'h0, contador}, 32'h0);
    chk("rst_alignErr", {31'h0, align_err}, 32'h0);
    chk("rst_overrun", {31'h0, overrun}, 32'h0);
`ifdef BYTE_UNSTRIPING_COUNT_EN
    chk("rst_byteCount", {16'h0, byte_count}, 32'h0);
`endif
    reset = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] w;
    int          exp_vld;
    int          exp_align;
  } vec_t;

  vec_t       tbl[8];
  logic [3:0] legal_pats[4];

  initial begin
    int n_vld;
    int n_align;
    reset = 1'b1;
    strobe = 1'b0;
    vpat = 4'b0000;
    lanes = 32'h0;
    model_reset();
    legal_pats[0] = 4'b0001;
    legal_pats[1] = 4'b0011;
    legal_pats[2] = 4'b0111;
    legal_pats[3] = 4'b1111;

    tbl[0] = '{4'b1111, 32'hA3A2A1A0, 4, 0};
    tbl[1] = '{4'b0011, 32'h55442211, 2, 0};
    tbl[2] = '{4'b0001, 32'h000000C7, 1, 0};
    tbl[3] = '{4'b0111, 32'h99332211, 3, 0};
    tbl[4] = '{4'b0101, 32'h12345678, 0, 1};
    tbl[5] = '{4'b1010, 32'h87654321, 0, 1};
    tbl[6] = '{4'b0000, 32'hDEADBEEF, 0, 0};
    tbl[7] = '{4'b1000, 32'hCAFEF00D, 0, 1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    apply_reset();

    // Single words: count of valid bytes and alignErr pulses, bytes checked by the model.
    for (int t = 0; t < 8; t++) begin
      apply_reset();
      n_vld = 0;
      n_align = 0;
      step(1'b1, tbl[t].v, tbl[t].w);
      n_vld += int'(obs_vld);
      n_align += int'(obs_align);
      for (int i = 0; i < 6; i++) begin
        step(1'b0, 4'b0000, $urandom);
        n_vld += int'(obs_vld);
        n_align += int'(obs_align);
      end
      chk("tbl_vld_count", 32'(n_vld), 32'(tbl[t].exp_vld));
      chk("tbl_align_count", 32'(n_align), 32'(tbl[t].exp_align));
      chk("tbl_end_contador", {30'h0, contador}, 32'h0);
    end

    // Illegal word followed by a legal word.
    apply_reset();
    step(1'b1, 4'b0101, 32'h01020304);
    chk("bad_align_pulse", {31'h0, align_err}, 32'h1);
    step(1'b1, 4'b0011, 32'h00002211);
    chk("bad_align_clear", {31'h0, align_err}, 32'h0);
    chk("after_bad_byte0", {24'h0, out}, 32'h11);
    step(1'b0, 4'b0000, 32'h0);
    chk("after_bad_byte1", {24'h0, out}, 32'h22);
    idle(2);

    // Three words every 4 cycles: 12 back-to-back valid bytes, no overrun.
    apply_reset();
    n_vld = 0;
    for (int w = 0; w < 3; w++) begin
      step(1'b1, 4'b1111, {8'(w*4+3), 8'(w*4+2), 8'(w*4+1), 8'(w*4)});
      n_vld += int'(obs_vld);
      for (int i = 0; i < 3; i++) begin
        step(1'b0, 4'b0000, 32'h0);
        n_vld += int'(obs_vld);
      end
    end
    chk("stream_vld_run", 32'(n_vld), 32'd12);
    chk("stream_last_byte", {24'h0, out}, 32'd11);
`ifdef BYTE_UNSTRIPING_COUNT_EN
    chk("stream_byteCount", {16'h0, byte_count}, 32'd12);
`endif
    step(1'b0, 4'b0000, 32'h0);
    chk("stream_end_vld", {31'h0, vld}, 32'h0);
    chk("stream_overrun", {31'h0, overrun}, 32'h0);

    // Three strobes on consecutive cycles: two words out, third dropped, overrun sticks.
    apply_reset();
    n_vld = 0;
    for (int w = 0; w < 3; w++) begin
      step(1'b1, 4'b1111, {8'h30 + 8'(w), 8'h20 + 8'(w), 8'h10 + 8'(w), 8'h00 + 8'(w)});
      n_vld += int'(obs_vld);
    end
    chk("ovr_set", {31'h0, overrun}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'b0000, 32'h0);
      n_vld += int'(obs_vld);
    end
    chk("ovr_vld_count", 32'(n_vld), 32'd8);
    chk("ovr_sticky", {31'h0, overrun}, 32'h1);

    // Asynchronous reset during the second byte of a word.
    apply_reset();
    step(1'b1, 4'b1111, 32'hD3D2D1D0);
    step(1'b0, 4'b0000, 32'h0);
    chk("mid_byte1", {24'h0, out}, 32'hD1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_out", {24'h0, out}, 32'h0);
    chk("async_vld", {31'h0, vld}, 32'h0);
    chk("async_contador", {30'h0, contador}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_vld = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 4'b0000, 32'h0);
      n_vld += int'(obs_vld);
    end
    chk("post_reset_no_bytes", 32'(n_vld), 32'd0);

    // Random strobes and patterns against the model.
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) < 8) step(1'b1, legal_pats[$urandom_range(0, 3)], $urandom);
        else step(1'b1, 4'($urandom_range(0, 15)), $urandom);
      end else begin
        step(1'b0, 4'($urandom_range(0, 15)), $urandom);
      end
    end
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
